// File: rtl/mem_req_ctrl.sv
// Request front-end for a single-port synchronous memory with registered read.
// Latency: write strobe 1 cycle after accept, read response valid 3 cycles after accept.
// Backpressure: one request outstanding; req_ready low until the FSM returns to IDLE,
// and a read response is held until the host accepts it.
// Optional feature: MEMCTRL_ADDR_CHECK_EN (out-of-range requests never reach memory).
module mem_req_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_w_data,
  output logic                  mem_w_en,
  output logic                  mem_r_en,
  input  logic [WIDTH-1:0]      mem_r_data,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPT, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]        mem_w_data_q, mem_w_data_d;
  logic                    mem_w_en_q, mem_w_en_d;
  logic                    mem_r_en_q, mem_r_en_d;
  logic                    addr_ok;

  // Decide whether the incoming address may be forwarded to the memory.
  always_comb begin
`ifdef MEMCTRL_ADDR_CHECK_EN
    addr_ok = (int'(req_addr) < DEPTH);
`else
    addr_ok = 1'b1;
`endif
  end

  // Next-state and registered-output logic of the request sequencer.
  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_w_data_d = mem_w_data_q;
    mem_w_en_d   = 1'b0;
    mem_r_en_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (addr_ok) begin
            mem_addr_d   = req_addr;
            mem_w_data_d = req_wdata;
            if (req_we) begin
              mem_w_en_d = 1'b1;
              state_d    = WRITE;
            end else begin
              mem_r_en_d = 1'b1;
              state_d    = READ;
            end
          end else if (!req_we) begin
            // Out-of-range read: answer immediately with an error, memory untouched.
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end
          // Out-of-range write is silently dropped; stay in IDLE.
        end
      end
      WRITE: state_d = IDLE;
      READ:  state_d = CAPT;
      CAPT: begin
        rsp_rdata_d = mem_r_data;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
      mem_w_en_q   <= 1'b0;
      mem_r_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_data_q <= mem_w_data_d;
      mem_w_en_q   <= mem_w_en_d;
      mem_r_en_q   <= mem_r_en_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_w_data = mem_w_data_q;
  assign mem_w_en   = mem_w_en_q;
  assign mem_r_en   = mem_r_en_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: directed vector table, hand-written corner sequences,
// and random traffic checked against an array model of the memory contents.
module tb_mem_req_ctrl;

  localparam int WIDTH = 16;
  localparam int AW    = 7;
`ifdef MEMCTRL_ADDR_CHECK_EN
  localparam int DEPTH = 100;
`else
  localparam int DEPTH = 128;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [AW-1:0]     req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [WIDTH-1:0]  rsp_rdata;
  logic [AW-1:0]     mem_addr;
  logic [WIDTH-1:0]  mem_w_data, mem_r_data;
  logic              mem_w_en, mem_r_en, busy;

  int n_chk  = 0;
  int n_fail = 0;

  // Memory device model (environment) and the bench's own reference contents.
  logic [WIDTH-1:0] dev_mem [0:127];
  logic [WIDTH-1:0] ref_mem [0:127];
  logic saw_w_en, saw_r_en;

  mem_req_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
    .mem_r_data(mem_r_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_w_en) dev_mem[mem_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= dev_mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Strobes must never overlap; sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) chk("w_en_r_en_exclusive", {31'd0, mem_w_en & mem_r_en}, 32'd0);
    if (mem_w_en) saw_w_en = 1'b1;
    if (mem_r_en) saw_r_en = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  // One request from handshake to completion. hold = cycles the response is
  // back-pressured; early = rsp_ready high before the response exists.
  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                        input int hold, input logic early, input logic [WIDTH-1:0] exp);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    wait_ready();
    step();                          // E0 has passed
    req_valid = 1'b0;
    if (we) begin
      chk("wr_w_en", {31'd0, mem_w_en}, 32'd1);
      chk("wr_addr", {25'd0, mem_addr}, {25'd0, a});
      chk("wr_data", {16'd0, mem_w_data}, {16'd0, d});
      chk("wr_busy", {31'd0, busy}, 32'd1);
      ref_mem[a] = d;
      step();
      chk("wr_w_en_off", {31'd0, mem_w_en}, 32'd0);
      chk("wr_ready_back", {31'd0, req_ready}, 32'd1);
    end else begin
      rsp_ready = early;
      chk("rd_r_en", {31'd0, mem_r_en}, 32'd1);
      chk("rd_addr", {25'd0, mem_addr}, {25'd0, a});
      chk("rd_no_rsp_e1", {31'd0, rsp_valid}, 32'd0);
      step();
      chk("rd_r_en_off", {31'd0, mem_r_en}, 32'd0);
      chk("rd_no_rsp_e2", {31'd0, rsp_valid}, 32'd0);
      step();                        // response visible at E0+3
      rsp_ready = (hold == 0);
      chk("rd_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rd_data", {16'd0, rsp_rdata}, {16'd0, exp});
      chk("rd_err", {31'd0, rsp_err}, 32'd0);
      for (int h = 0; h < hold; h++) begin
        step();
        chk("rd_hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_hold_data", {16'd0, rsp_rdata}, {16'd0, exp});
        chk("rd_hold_ready", {31'd0, req_ready}, 32'd0);
        if (h == hold - 1) rsp_ready = 1'b1;
      end
      step();
      chk("rd_done_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rd_done_idle", {31'd0, req_ready}, 32'd1);
      rsp_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    int               hold;
    logic             early;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs [0:6];
  int   acc_t [0:3];

  initial begin
    int cnt;
    for (int i = 0; i < 128; i++) begin dev_mem[i] = '0; ref_mem[i] = '0; end
    mem_r_data = '0;
    saw_w_en = 1'b0; saw_r_en = 1'b0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    vecs[0] = '{1'b1, 7'd5,  16'hA5A5, 0, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 7'd5,  16'h0000, 0, 1'b0, 16'hA5A5};
    vecs[2] = '{1'b0, 7'd5,  16'h0000, 4, 1'b0, 16'hA5A5};
    vecs[3] = '{1'b1, 7'd99, 16'h1234, 0, 1'b0, 16'h0000};
    vecs[4] = '{1'b0, 7'd99, 16'h0000, 1, 1'b1, 16'h1234};
    vecs[5] = '{1'b0, 7'd7,  16'h0000, 0, 1'b1, 16'h0000};
    vecs[6] = '{1'b0, 7'd5,  16'h0000, 2, 1'b1, 16'hA5A5};

    // Reset state
    step(); step();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_w_en", {31'd0, mem_w_en}, 32'd0);
    chk("rst_r_en", {31'd0, mem_r_en}, 32'd0);
    chk("rst_addr", {25'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {16'd0, mem_w_data}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    step();

    // Directed vector table
    for (int i = 0; i < 7; i++)
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold, vecs[i].early, vecs[i].exp);

    // Back-to-back writes with req_valid held: accepted every second cycle
    cnt = 0;
    req_valid = 1'b1; req_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      req_addr = AW'(k); req_wdata = WIDTH'(k + 1);
      while (!req_ready && n < 20) begin step(); cnt++; n++; end
      chk("b2b_ready", {31'd0, req_ready}, 32'd1);
      acc_t[k] = cnt;
      ref_mem[k] = WIDTH'(k + 1);
      step(); cnt++;
    end
    req_valid = 1'b0;
    for (int k = 1; k < 4; k++) chk("b2b_spacing", acc_t[k] - acc_t[k-1], 32'd2);
    for (int k = 0; k < 4; k++) do_req(1'b0, AW'(k), '0, 0, 1'b0, WIDTH'(k + 1));

    // Reset while the read is in its capture cycle: response is lost
    dev_mem[9] = 16'hBEEF;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd9;
    wait_ready();
    step(); req_valid = 1'b0;       // READ
    step();                         // CAPT
    chk("capt_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    chk("rst_capt_idle", {31'd0, req_ready}, 32'd1);
    chk("rst_capt_busy", {31'd0, busy}, 32'd0);
    chk("rst_capt_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_capt_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rsp_ready = 1'b0;
    ref_mem[9] = 16'hBEEF;          // memory content itself is unaffected by controller reset

`ifdef MEMCTRL_ADDR_CHECK_EN
    // Out-of-range read: immediate error response, memory never strobed
    saw_r_en = 1'b0; saw_w_en = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd120;
    wait_ready();
    step(); req_valid = 1'b0;
    chk("oor_rd_valid", {31'd0, rsp_valid}, 32'd1);
    chk("oor_rd_err", {31'd0, rsp_err}, 32'd1);
    chk("oor_rd_data", {16'd0, rsp_rdata}, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("oor_rd_done", {31'd0, rsp_valid}, 32'd0);
    chk("oor_rd_no_r_en", {31'd0, saw_r_en}, 32'd0);
    // Out-of-range write: dropped, controller stays ready
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'd120; req_wdata = 16'hFFFF;
    wait_ready();
    step(); req_valid = 1'b0;
    chk("oor_wr_ready", {31'd0, req_ready}, 32'd1);
    step(); step();
    chk("oor_wr_no_w_en", {31'd0, saw_w_en}, 32'd0);
`endif

    // Random traffic against the reference contents
    for (int i = 0; i < 60; i++) begin
      logic           we;
      logic [AW-1:0]  a;
      logic [WIDTH-1:0] d;
      we = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, DEPTH - 1));
      d  = WIDTH'($urandom);
      do_req(we, a, d, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), ref_mem[a]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
